// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
//   Frame-rate (48 kHz) controller for the I2S sine synth. Walks a note table
//   of (freq, duration) pairs held in an external synchronous ROM, inserts an
//   optional silent gap between notes, and arbitrates the table against a live
//   key request. The key always wins the synth. All outputs are registered.
//
// Build option
//   TONE_SEQ_KEY_PAUSE_EN  defined : a held key freezes the FSM and duration
//                                    counter. The interrupted note resumes
//                                    with its remaining length after release.
//                          undefined: the sequencer keeps running silently
//                                    under the key, so song timing is kept.
//
// Parameters
//   ADDR_W       note-table address width (2**ADDR_W entries)
//   DUR_W        duration / counter width, in samples
//   GAP_SAMPLES  silent samples between notes (0 = no gap)
//
// Ports
//   DACLRCLK   in   frame clock, all logic on posedge
//   rst        in   asynchronous active-high reset
//   play       in   start the sequence from address 0 (ignored while busy)
//   stop       in   abort the sequence (wins over play)
//   loop       in   restart at address 0 at the end of the table
//   key_valid  in   live key held, has priority over the sequencer
//   key_freq   in   live key frequency, Hz
//   rom_addr   out  note-table address
//   rom_freq   in   table frequency, Hz (0 = rest), valid 1 cycle after rom_addr
//   rom_dur    in   table duration, samples (0 = terminator)
//   f_out      out  frequency to the synth
//   tone_en    out  synth enable
//   busy       out  sequencer not idle
//   done       out  1-cycle pulse on normal (non-loop) completion
//   src        out  0 = sequencer drives f_out, 1 = key drives f_out
// -----------------------------------------------------------------------------
module tone_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int DUR_W       = 16,
  parameter int GAP_SAMPLES = 480
) (
  input  logic              DACLRCLK,
  input  logic              rst,
  input  logic              play,
  input  logic              stop,
  input  logic              loop,
  input  logic              key_valid,
  input  logic [15:0]       key_freq,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_freq,
  input  logic [DUR_W-1:0]  rom_dur,
  output logic [15:0]       f_out,
  output logic              tone_en,
  output logic              busy,
  output logic              done,
  output logic              src
);

  if (GAP_SAMPLES < 0 || (GAP_SAMPLES > 0 && ((GAP_SAMPLES - 1) >> DUR_W) != 0)) begin : g_gap_chk
    $error("tone_sequencer: GAP_SAMPLES-1 does not fit in DUR_W bits");
  end

  localparam bit               HAS_GAP  = (GAP_SAMPLES > 0);
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'((GAP_SAMPLES > 0) ? GAP_SAMPLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_e;

  state_e              state_q, state_d;
  logic [DUR_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         seq_freq_q, seq_freq_d;
  logic [15:0]         f_out_q, f_out_d;
  logic                tone_en_q, tone_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                src_q, src_d;
  logic                step;
  logic                hold;

`ifdef TONE_SEQ_KEY_PAUSE_EN
  assign hold = key_valid;
`else
  assign hold = 1'b0;
`endif

  // Next-state logic. 'step' marks leaving PLAY/GAP toward the next entry;
  // stepping past the last address behaves like hitting a terminator.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    seq_freq_d = seq_freq_q;
    done_d     = 1'b0;
    step       = 1'b0;
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
    end else if (!hold) begin
      unique case (state_q)
        IDLE: begin
          if (play && !stop) begin
            state_d = FETCH;
            addr_d  = '0;
          end
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          if (rom_dur == '0) begin
            if (loop) begin
              state_d = FETCH;
              addr_d  = '0;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            state_d    = PLAY;
            seq_freq_d = rom_freq;
            cnt_d      = rom_dur - DUR_W'(1);
          end
        end
        PLAY: begin
          if (cnt_q == '0) begin
            if (HAS_GAP) begin
              state_d = GAP;
              cnt_d   = GAP_LAST;
            end else begin
              step = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - DUR_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == '0) step = 1'b1;
          else             cnt_d = cnt_q - DUR_W'(1);
        end
        default: state_d = IDLE;
      endcase
      if (step) begin
        if (addr_q == '1 && !loop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          // with loop set, the increment wraps naturally to address 0
          state_d = FETCH;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
    end
  end

  // Arbitration looks at the next state so the first note appears on the
  // same edge that enters PLAY (two edges after play is sampled).
  always_comb begin
    f_out_d   = f_out_q;
    tone_en_d = 1'b0;
    src_d     = 1'b0;
    busy_d    = (state_d != IDLE);
    if (key_valid) begin
      f_out_d   = key_freq;
      tone_en_d = (key_freq != 16'd0);
      src_d     = 1'b1;
    end else if (state_d == PLAY) begin
      f_out_d   = seq_freq_d;
      tone_en_d = (seq_freq_d != 16'd0);
    end
  end

  always_ff @(posedge DACLRCLK or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      seq_freq_q <= '0;
      f_out_q    <= '0;
      tone_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      src_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      seq_freq_q <= seq_freq_d;
      f_out_q    <= f_out_d;
      tone_en_q  <= tone_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      src_q      <= src_d;
    end
  end

  assign rom_addr = addr_q;
  assign f_out    = f_out_q;
  assign tone_en  = tone_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign src      = src_q;

endmodule
